// File: rtl/arf_sequencer.sv
// arf_sequencer: multi-cycle controller for the address register file
// (PC, AR, SP). Takes one command at a time over a valid/ready handshake
// and walks it through a fixed sequence of register-enable / memory-strobe
// cycles.
//
// Handshake: a command transfers on a rising edge where CmdValid and
// CmdReady are both 1. CmdReady is 1 only in IDLE. Cmd and CmdLen are
// sampled only on that edge. Done pulses for one cycle on the last cycle of
// every command. MemReady is looked at only while a memory access is
// active (MemEn = 1).
module arf_sequencer #(
    parameter int MAX_BURST = 4,
    parameter int LEN_W     = 3
) (
    input  logic             Clock,
    input  logic             Reset,
    input  logic             CmdValid,
    input  logic [2:0]       Cmd,
    input  logic [LEN_W-1:0] CmdLen,
    output logic             CmdReady,
    input  logic             MemReady,
    output logic [2:0]       RegSel,
    output logic [2:0]       FunSel,
    output logic [1:0]       OutCSel,
    output logic [1:0]       OutDSel,
    output logic             MemEn,
    output logic             MemWrite,
    output logic             Done,
    output logic             Error,
    output logic [3:0]       DbgState
);

    localparam logic [2:0] OP_FETCH = 3'b000;
    localparam logic [2:0] OP_PUSH  = 3'b001;
    localparam logic [2:0] OP_POP   = 3'b010;
    localparam logic [2:0] OP_LDPC  = 3'b011;
    localparam logic [2:0] OP_LDAR  = 3'b100;
    localparam logic [2:0] OP_CLR   = 3'b101;

    localparam logic [2:0] FN_DEC   = 3'b000;
    localparam logic [2:0] FN_INC   = 3'b001;
    localparam logic [2:0] FN_LOAD  = 3'b010;
    localparam logic [2:0] FN_CLEAR = 3'b011;

    // Active-low enables: bit2 PC, bit1 AR, bit0 SP.
    localparam logic [2:0] EN_NONE  = 3'b111;
    localparam logic [2:0] EN_PC    = 3'b011;
    localparam logic [2:0] EN_AR    = 3'b101;
    localparam logic [2:0] EN_SP    = 3'b110;
    localparam logic [2:0] EN_ALL   = 3'b000;

    localparam logic [1:0] SEL_PC   = 2'b00;
    localparam logic [1:0] SEL_SP   = 2'b11;

    localparam logic [LEN_W-1:0] LEN_ONE = LEN_W'(1);
    localparam logic [LEN_W-1:0] LEN_MAX = LEN_W'(MAX_BURST);

    typedef enum logic [3:0] {
        S_IDLE   = 4'd0,
        S_F_ADDR = 4'd1,
        S_F_INC  = 4'd2,
        S_PU_DEC = 4'd3,
        S_PU_WR  = 4'd4,
        S_PO_RD  = 4'd5,
        S_PO_INC = 4'd6,
        S_LOAD   = 4'd7,
        S_CLR    = 4'd8,
        S_ERR    = 4'd9
    } state_t;

    state_t           r_state;
    state_t           w_next;
    logic [LEN_W-1:0] r_cnt;
    logic             r_ld_ar;
    logic             w_accept;
    logic [LEN_W-1:0] w_len;

    assign w_accept = CmdValid && (r_state == S_IDLE);
    assign DbgState = r_state;

    // Clamp the requested burst length into 1..MAX_BURST.
    always_comb begin
        w_len = CmdLen;
        if (CmdLen == '0) begin
            w_len = LEN_ONE;
        end else if (CmdLen > LEN_MAX) begin
            w_len = LEN_MAX;
        end
    end

    // State register; reset aborts any command in flight.
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Burst counter: loaded on FETCH accept, counts down on each PC increment, never wraps.
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            r_cnt <= '0;
        end else if (w_accept && (Cmd == OP_FETCH)) begin
            r_cnt <= w_len;
        end else if ((r_state == S_F_INC) && (r_cnt != '0)) begin
            r_cnt <= r_cnt - LEN_ONE;
        end
    end

    // Remember whether an accepted load targets AR (LDAR) or PC (LDPC).
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            r_ld_ar <= 1'b0;
        end else if (w_accept) begin
            r_ld_ar <= (Cmd == OP_LDAR);
        end
    end

    // Next-state and Moore output decode (Done in PU_WR also follows MemReady).
    always_comb begin
        w_next   = r_state;
        CmdReady = 1'b0;
        RegSel   = EN_NONE;
        FunSel   = FN_DEC;
        OutCSel  = SEL_PC;
        OutDSel  = SEL_PC;
        MemEn    = 1'b0;
        MemWrite = 1'b0;
        Done     = 1'b0;
        Error    = 1'b0;
        case (r_state)
            S_IDLE: begin
                CmdReady = 1'b1;
                if (CmdValid) begin
                    case (Cmd)
                        OP_FETCH: w_next = S_F_ADDR;
                        OP_PUSH:  w_next = S_PU_DEC;
                        OP_POP:   w_next = S_PO_RD;
                        OP_LDPC:  w_next = S_LOAD;
                        OP_LDAR:  w_next = S_LOAD;
                        OP_CLR:   w_next = S_CLR;
                        default:  w_next = S_ERR;
                    endcase
                end
            end
            S_F_ADDR: begin
                OutCSel = SEL_PC;
                OutDSel = SEL_PC;
                MemEn   = 1'b1;
                if (MemReady) w_next = S_F_INC;
            end
            S_F_INC: begin
                RegSel = EN_PC;
                FunSel = FN_INC;
                if (r_cnt <= LEN_ONE) begin
                    Done   = 1'b1;
                    w_next = S_IDLE;
                end else begin
                    w_next = S_F_ADDR;
                end
            end
            S_PU_DEC: begin
                RegSel = EN_SP;
                FunSel = FN_DEC;
                w_next = S_PU_WR;
            end
            S_PU_WR: begin
                OutCSel  = SEL_SP;
                OutDSel  = SEL_SP;
                MemEn    = 1'b1;
                MemWrite = 1'b1;
                if (MemReady) begin
                    Done   = 1'b1;
                    w_next = S_IDLE;
                end
            end
            S_PO_RD: begin
                OutCSel = SEL_SP;
                OutDSel = SEL_SP;
                MemEn   = 1'b1;
                if (MemReady) w_next = S_PO_INC;
            end
            S_PO_INC: begin
                RegSel = EN_SP;
                FunSel = FN_INC;
                Done   = 1'b1;
                w_next = S_IDLE;
            end
            S_LOAD: begin
                RegSel = r_ld_ar ? EN_AR : EN_PC;
                FunSel = FN_LOAD;
                Done   = 1'b1;
                w_next = S_IDLE;
            end
            S_CLR: begin
                RegSel = EN_ALL;
                FunSel = FN_CLEAR;
                Done   = 1'b1;
                w_next = S_IDLE;
            end
            S_ERR: begin
                Done   = 1'b1;
                Error  = 1'b1;
                w_next = S_IDLE;
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_arf_sequencer.sv
// Bench for arf_sequencer. A command is modelled as a list of cycle steps
// (memory steps wait for MemReady); a small register file driven by the DUT
// outputs is compared against the register effect each step should have.
module tb_arf_sequencer;
    localparam int LEN_W     = 3;
    localparam int MAX_BURST = 4;
    localparam logic [14:0] IDLE_VEC = 15'b1_111_000_00_00_0_0_0_0;

    localparam int EF_NONE = 0, EF_PC_INC = 1, EF_SP_DEC = 2, EF_SP_INC = 3,
                   EF_LD_PC = 4, EF_LD_AR = 5, EF_CLR = 6;

    logic             Clock = 1'b0;
    logic             Reset;
    logic             CmdValid;
    logic [2:0]       Cmd;
    logic [LEN_W-1:0] CmdLen;
    logic             CmdReady;
    logic             MemReady;
    logic [2:0]       RegSel;
    logic [2:0]       FunSel;
    logic [1:0]       OutCSel;
    logic [1:0]       OutDSel;
    logic             MemEn;
    logic             MemWrite;
    logic             Done;
    logic             Error;
    logic [3:0]       DbgState;

    arf_sequencer #(.MAX_BURST(MAX_BURST), .LEN_W(LEN_W)) dut (
        .Clock(Clock), .Reset(Reset), .CmdValid(CmdValid), .Cmd(Cmd),
        .CmdLen(CmdLen), .CmdReady(CmdReady), .MemReady(MemReady),
        .RegSel(RegSel), .FunSel(FunSel), .OutCSel(OutCSel), .OutDSel(OutDSel),
        .MemEn(MemEn), .MemWrite(MemWrite), .Done(Done), .Error(Error),
        .DbgState(DbgState)
    );

    // clock / reset block
    always #5 Clock = ~Clock;

    int checks = 0;
    int errors = 0;
    bit chk_en = 1'b0;

    typedef struct packed {
        logic [2:0] rs;
        logic [2:0] fs;
        logic [1:0] cs;
        logic [1:0] ds;
        logic       me;
        logic       mw;
        logic       dn;   // Done unconditionally
        logic       dnr;  // Done when MemReady
        logic       er;
        logic       mem;  // waits for MemReady
        logic [2:0] eff;
    } step_t;

    step_t q[$];

    logic [15:0] pc = 16'h1000, ar = 16'h2000, sp = 16'h3000;
    logic [15:0] e_pc = 16'h1000, e_ar = 16'h2000, e_sp = 16'h3000;
    logic [15:0] ld_data = 16'h5a5a;

    function automatic logic [15:0] apply_fn(input logic [15:0] v, input logic [2:0] f);
        case (f)
            3'b000:  return v - 16'd1;
            3'b001:  return v + 16'd1;
            3'b010:  return ld_data;
            3'b011:  return 16'd0;
            default: return v;
        endcase
    endfunction

    // Register file driven by the sequencer's enables and function select.
    always @(posedge Clock) begin
        if (!RegSel[2]) pc <= apply_fn(pc, FunSel);
        if (!RegSel[1]) ar <= apply_fn(ar, FunSel);
        if (!RegSel[0]) sp <= apply_fn(sp, FunSel);
    end

    function automatic step_t mk(input logic [2:0] rs, input logic [2:0] fs,
                                 input logic [1:0] sel, input logic me, input logic mw,
                                 input logic dn, input logic dnr, input logic er,
                                 input int eff);
        step_t s;
        s.rs = rs; s.fs = fs; s.cs = sel; s.ds = sel; s.me = me; s.mw = mw;
        s.dn = dn; s.dnr = dnr; s.er = er; s.mem = me; s.eff = 3'(eff);
        return s;
    endfunction

    task automatic build(input logic [2:0] c, input logic [LEN_W-1:0] l);
        int n;
        n = (l == 0) ? 1 : ((int'(l) > MAX_BURST) ? MAX_BURST : int'(l));
        case (c)
            3'd0: for (int i = 0; i < n; i++) begin
                q.push_back(mk(3'b111, 3'b000, 2'b00, 1, 0, 0, 0, 0, EF_NONE));
                q.push_back(mk(3'b011, 3'b001, 2'b00, 0, 0, i == n - 1, 0, 0, EF_PC_INC));
            end
            3'd1: begin
                q.push_back(mk(3'b110, 3'b000, 2'b00, 0, 0, 0, 0, 0, EF_SP_DEC));
                q.push_back(mk(3'b111, 3'b000, 2'b11, 1, 1, 0, 1, 0, EF_NONE));
            end
            3'd2: begin
                q.push_back(mk(3'b111, 3'b000, 2'b11, 1, 0, 0, 0, 0, EF_NONE));
                q.push_back(mk(3'b110, 3'b001, 2'b00, 0, 0, 1, 0, 0, EF_SP_INC));
            end
            3'd3: q.push_back(mk(3'b011, 3'b010, 2'b00, 0, 0, 1, 0, 0, EF_LD_PC));
            3'd4: q.push_back(mk(3'b101, 3'b010, 2'b00, 0, 0, 1, 0, 0, EF_LD_AR));
            3'd5: q.push_back(mk(3'b000, 3'b011, 2'b00, 0, 0, 1, 0, 0, EF_CLR));
            default: q.push_back(mk(3'b111, 3'b000, 2'b00, 0, 0, 1, 0, 1, EF_NONE));
        endcase
    endtask

    // Reference model: accept when idle, advance a step unless it waits on memory.
    always @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            q.delete();
        end else if (q.size() == 0) begin
            if (CmdValid) build(Cmd, CmdLen);
        end else if (!(q[0].mem && !MemReady)) begin
            case (int'(q[0].eff))
                EF_PC_INC: e_pc = e_pc + 16'd1;
                EF_SP_DEC: e_sp = e_sp - 16'd1;
                EF_SP_INC: e_sp = e_sp + 16'd1;
                EF_LD_PC:  e_pc = ld_data;
                EF_LD_AR:  e_ar = ld_data;
                EF_CLR: begin e_pc = 16'd0; e_ar = 16'd0; e_sp = 16'd0; end
                default: ;
            endcase
            void'(q.pop_front());
        end
    end

    task automatic check(input string name, input logic [47:0] got, input logic [47:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
        end
    endtask

    function automatic logic [14:0] out_vec();
        return {CmdReady, RegSel, FunSel, OutCSel, OutDSel, MemEn, MemWrite, Done, Error};
    endfunction

    // Compare process: outputs and register file against the model every cycle.
    always @(negedge Clock) begin
        logic [14:0] exp_v;
        if (chk_en) begin
            if (q.size() == 0) begin
                exp_v = IDLE_VEC;
            end else begin
                exp_v = {1'b0, q[0].rs, q[0].fs, q[0].cs, q[0].ds, q[0].me, q[0].mw,
                         q[0].dn | (q[0].dnr & MemReady), q[0].er};
            end
            check("outputs", 48'(out_vec()), 48'(exp_v));
            check("regfile", {pc, ar, sp}, {e_pc, e_ar, e_sp});
        end
    end

    task automatic wait_idle();
        int n = 0;
        while (q.size() != 0 && n < 200) begin
            @(posedge Clock); #1;
            n++;
        end
        if (n >= 200) begin
            checks++; errors++;
            $display("FAIL idle_wait: sequencer still busy after %0d cycles, required idle", n);
        end
    endtask

    // driver: issue one command and measure cycles from accept edge to Done
    task automatic run_cmd(input logic [2:0] c, input logic [LEN_W-1:0] l,
                           input int stall, input int exp_lat, input string name);
        int lat = 0;
        bit got_done = 0;
        int st = stall;
        wait_idle();
        CmdValid = 1'b1; Cmd = c; CmdLen = l;
        @(posedge Clock); #1;
        CmdValid = 1'b0;
        while (!got_done && lat < 200) begin
            lat++;
            if (st > 0 && q.size() > 0 && q[0].mem) begin
                MemReady = 1'b0; st--;
            end else begin
                MemReady = 1'b1;
            end
            @(negedge Clock);
            if (Done) got_done = 1;
            @(posedge Clock); #1;
        end
        MemReady = 1'b1;
        check(name, 48'(lat), 48'(exp_lat));
    endtask

    initial begin
        logic [15:0] pc0, sp0;
        logic [47:0] regs0;
        int d1, d2, cyc;
        Reset = 1'b1; CmdValid = 1'b0; Cmd = '0; CmdLen = '0; MemReady = 1'b1;
        #2;
        check("reset_outputs_async", 48'(out_vec()), 48'(IDLE_VEC));
        repeat (2) @(posedge Clock);
        #1;
        check("reset_outputs", 48'(out_vec()), 48'(IDLE_VEC));
        Reset = 1'b0;
        chk_en = 1'b1;

        pc0 = pc;
        run_cmd(3'd0, 3'd2, 0, 4, "fetch2_latency");
        check("fetch2_pc", 48'(pc), 48'(pc0 + 16'd2));

        sp0 = sp;
        run_cmd(3'd1, 3'd0, 3, 5, "push_stall3_latency");
        check("push_sp", 48'(sp), 48'(sp0 - 16'd1));

        // POP followed by LDAR with CmdValid held high throughout
        wait_idle();
        CmdValid = 1'b1; Cmd = 3'd2; MemReady = 1'b1;
        @(posedge Clock); #1;
        Cmd = 3'd4;
        d1 = 0; d2 = 0; cyc = 0;
        while (d2 == 0 && cyc < 50) begin
            cyc++;
            @(negedge Clock);
            if (Done && d1 == 0) d1 = cyc;
            else if (Done) d2 = cyc;
            @(posedge Clock); #1;
        end
        CmdValid = 1'b0;
        check("pop_done_cycle", 48'(d1), 48'd2);
        check("ldar_done_cycle", 48'(d2), 48'd4);
        check("ldar_ar", 48'(ar), 48'h5a5a);

        pc0 = pc;
        run_cmd(3'd0, 3'd0, 0, 2, "fetch_len0_latency");
        check("fetch_len0_pc", 48'(pc), 48'(pc0 + 16'd1));
        pc0 = pc;
        run_cmd(3'd0, 3'd7, 2, 10, "fetch_len7_latency");
        check("fetch_len7_pc", 48'(pc), 48'(pc0 + 16'd4));

        regs0 = {pc, ar, sp};
        run_cmd(3'd6, 3'd0, 0, 1, "illegal_latency");
        check("illegal_regs", {pc, ar, sp}, regs0);

        run_cmd(3'd5, 3'd0, 0, 1, "clr_latency");
        check("clr_regs", {pc, ar, sp}, 48'd0);
        run_cmd(3'd3, 3'd0, 0, 1, "ldpc_latency");
        check("ldpc_pc", 48'(pc), 48'h5a5a);

        // asynchronous reset during a fetch memory stall
        wait_idle();
        pc0 = pc;
        CmdValid = 1'b1; Cmd = 3'd0; CmdLen = 3'd1; MemReady = 1'b0;
        @(posedge Clock); #1;
        CmdValid = 1'b0;
        @(posedge Clock); #2;
        check("stall_memen", 48'(MemEn), 48'd1);
        Reset = 1'b1;
        #1;
        check("midcmd_reset_outputs", 48'(out_vec()), 48'(IDLE_VEC));
        @(posedge Clock); #1;
        Reset = 1'b0;
        MemReady = 1'b1;
        check("after_reset_ready", 48'(CmdReady), 48'd1);
        repeat (3) @(posedge Clock);
        #1;
        check("after_reset_pc", 48'(pc), 48'(pc0));

        // randomized traffic
        for (int i = 0; i < 3000; i++) begin
            CmdValid = 1'($urandom_range(0, 1));
            Cmd      = 3'($urandom_range(0, 7));
            CmdLen   = LEN_W'($urandom_range(0, 7));
            MemReady = ($urandom_range(0, 3) != 0);
            ld_data  = 16'($urandom);
            @(posedge Clock); #1;
        end
        CmdValid = 1'b0;
        MemReady = 1'b1;
        wait_idle();
        @(posedge Clock); #1;
        chk_en = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
